// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants shared by the timing and colour stages.
// Counter origin is the start of the sync pulse on each axis.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;

  localparam int unsigned TILE_SIZE = 32;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable plus registered sync/active flags.
// Ports: clk, rst, en_i; count_o, wrap_o (comb), sync_n_o, active_o (regs).
import vga_pkg::*;

module vga_axis_counter #(
  parameter int unsigned TOTAL     = 800,
  parameter int unsigned SYNC      = 96,
  parameter int unsigned ACT_START = 144,
  parameter int unsigned ACT_END   = 784
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output cnt_t count_o,
  output logic wrap_o,
  output logic sync_n_o,
  output logic active_o
);

  localparam cnt_t LAST  = cnt_t'(TOTAL - 1);
  localparam cnt_t SYNCW = cnt_t'(SYNC);
  localparam cnt_t A0    = cnt_t'(ACT_START);
  localparam cnt_t A1    = cnt_t'(ACT_END);

  cnt_t cnt_q, cnt_d;
  logic sync_n_q, sync_n_d;
  logic act_q, act_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  // Flags decode the next count so they land on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
    sync_n_d = (cnt_d >= SYNCW);
    act_d    = (cnt_d >= A0) && (cnt_d < A1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sync_n_q <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sync_n_q <= sync_n_d;
      act_q    <= act_d;
    end
  end

  assign count_o  = cnt_q;
  assign sync_n_o = sync_n_q;
  assign active_o = act_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, syncs, enable, strobes.
// Ports: clk, rst in; h_count, v_count, hsync, vsync, display_en, pix_stb,
// line_start, frame_start out. Macro VGA_SYNC_PIPE_EN adds a sync delay stage.
import vga_pkg::*;

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       pix_stb,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_A0  = H_SYNC + H_BP;
  localparam int unsigned V_A0  = V_SYNC + V_BP;

  localparam int unsigned DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_hit;
  logic             pix_q;
  logic             ls_q;
  logic             fs_q;

  logic h_wrap, v_wrap;
  logic h_sync_n, v_sync_n;
  logic h_act, v_act;
  cnt_t h_cnt, v_cnt;
  sync_t raw;

  assign div_hit = (div_q == DIV_LAST);
  assign div_d   = div_hit ? '0 : div_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      pix_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      pix_q <= div_hit;
      ls_q  <= h_wrap;
      fs_q  <= h_wrap && v_wrap;
    end
  end

  // Counters step at the end of each clk in which pix_stb is high.
  vga_axis_counter #(
    .TOTAL    (H_TOT),
    .SYNC     (H_SYNC),
    .ACT_START(H_A0),
    .ACT_END  (H_A0 + H_ACTIVE)
  ) u_h (
    .clk     (clk),
    .rst     (rst),
    .en_i    (pix_q),
    .count_o (h_cnt),
    .wrap_o  (h_wrap),
    .sync_n_o(h_sync_n),
    .active_o(h_act)
  );

  vga_axis_counter #(
    .TOTAL    (V_TOT),
    .SYNC     (V_SYNC),
    .ACT_START(V_A0),
    .ACT_END  (V_A0 + V_ACTIVE)
  ) u_v (
    .clk     (clk),
    .rst     (rst),
    .en_i    (h_wrap),
    .count_o (v_cnt),
    .wrap_o  (v_wrap),
    .sync_n_o(v_sync_n),
    .active_o(v_act)
  );

  assign raw.hsync = h_sync_n;
  assign raw.vsync = v_sync_n;
  assign raw.de    = h_act && v_act;

`ifdef VGA_SYNC_PIPE_EN
  // One pixel of delay to match the registered colour output.
  sync_t pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};
    end else if (pix_q) begin
      pipe_q <= raw;
    end
  end

  assign hsync      = pipe_q.hsync;
  assign vsync      = pipe_q.vsync;
  assign display_en = pipe_q.de;
`else
  assign hsync      = raw.hsync;
  assign vsync      = raw.vsync;
  assign display_en = raw.de;
`endif

  assign h_count     = h_cnt;
  assign v_count     = v_cnt;
  assign pix_stb     = pix_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, CLK_DIV=4,
// and a reduced-timing instance for whole-frame and boundary checks.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst4, rsm;

  logic [9:0] a_h, a_v, b_h, b_v, s_h, s_v;
  logic a_hs, a_vs, a_de, a_px, a_ls, a_fs;
  logic b_hs, b_vs, b_de, b_px, b_ls, b_fs;
  logic s_hs, s_vs, s_de, s_px, s_ls, s_fs;

  vga_timing_gen dut (
    .clk(clk), .rst(rst),
    .h_count(a_h), .v_count(a_v),
    .hsync(a_hs), .vsync(a_vs), .display_en(a_de),
    .pix_stb(a_px), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4),
    .h_count(b_h), .v_count(b_v),
    .hsync(b_hs), .vsync(b_vs), .display_en(b_de),
    .pix_stb(b_px), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dsm (
    .clk(clk), .rst(rsm),
    .h_count(s_h), .v_count(s_v),
    .hsync(s_hs), .vsync(s_vs), .display_en(s_de),
    .pix_stb(s_px), .line_start(s_ls), .frame_start(s_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         p;
    logic [9:0] h, v;
    logic       hs, vs, de, ls;
    logic       hsp, vsp, dep;
  } vec_t;

  typedef struct {
    int   p;
    logic de, dep;
  } bvec_t;

  vec_t  tv[16];
  bvec_t bv[5];

  initial begin
    int pos;
    int bad_pix, bad_h, npix, first_pix, nls;
    int ls_k[2];
    int fs_n, vs_low, de_hi;
    int fs_k[3];
    logic [9:0] fs_h, fs_v;
    logic fs_ls;
    logic [9:0] exp_h;

    //         p      h    v   hs vs de ls hsp vsp dep
    tv[0]  = '{0,     0,   0,  0, 0, 0, 0, 1,  1,  0};
    tv[1]  = '{1,     1,   0,  0, 0, 0, 0, 0,  0,  0};
    tv[2]  = '{95,    95,  0,  0, 0, 0, 0, 0,  0,  0};
    tv[3]  = '{96,    96,  0,  1, 0, 0, 0, 0,  0,  0};
    tv[4]  = '{97,    97,  0,  1, 0, 0, 0, 1,  0,  0};
    tv[5]  = '{799,   799, 0,  1, 0, 0, 0, 1,  0,  0};
    tv[6]  = '{800,   0,   1,  0, 0, 0, 1, 1,  0,  0};
    tv[7]  = '{801,   1,   1,  0, 0, 0, 0, 0,  0,  0};
    tv[8]  = '{1600,  0,   2,  0, 1, 0, 1, 1,  0,  0};
    tv[9]  = '{1601,  1,   2,  0, 1, 0, 0, 0,  1,  0};
    tv[10] = '{28143, 143, 35, 1, 1, 0, 0, 1,  1,  0};
    tv[11] = '{28144, 144, 35, 1, 1, 1, 0, 1,  1,  0};
    tv[12] = '{28145, 145, 35, 1, 1, 1, 0, 1,  1,  1};
    tv[13] = '{28783, 783, 35, 1, 1, 1, 0, 1,  1,  1};
    tv[14] = '{28784, 784, 35, 1, 1, 0, 0, 1,  1,  1};
    tv[15] = '{28785, 785, 35, 1, 1, 0, 0, 1,  1,  0};

    // Reduced timing: h active 5..12, v active 3..6, 15x8 raster.
    bv[0] = '{49,  0, 0};
    bv[1] = '{50,  1, 0};
    bv[2] = '{102, 1, 1};
    bv[3] = '{103, 0, 1};
    bv[4] = '{110, 0, 0};

    rst = 1'b1; rst4 = 1'b1; rsm = 1'b1;
    repeat (3) tick();

    chk("rst.h", a_h, 0);
    chk("rst.v", a_v, 0);
    chk("rst.hs", a_hs, PIPE ? 1 : 0);
    chk("rst.vs", a_vs, PIPE ? 1 : 0);
    chk("rst.de", a_de, 0);
    chk("rst.pix", a_px, 0);
    chk("rst.ls", a_ls, 0);
    chk("rst.fs", a_fs, 0);

    // Default timing, CLK_DIV=1.
    rst = 1'b0;
    pos = -1;
    for (int i = 0; i < 16; i++) begin
      while (pos < tv[i].p) begin
        tick();
        pos++;
      end
      chk($sformatf("v%0d.h", i), a_h, tv[i].h);
      chk($sformatf("v%0d.v", i), a_v, tv[i].v);
      chk($sformatf("v%0d.hs", i), a_hs,
          PIPE ? tv[i].hsp : tv[i].hs);
      chk($sformatf("v%0d.vs", i), a_vs,
          PIPE ? tv[i].vsp : tv[i].vs);
      chk($sformatf("v%0d.de", i), a_de,
          PIPE ? tv[i].dep : tv[i].de);
      chk($sformatf("v%0d.ls", i), a_ls, tv[i].ls);
      chk($sformatf("v%0d.fs", i), a_fs, 0);
      chk($sformatf("v%0d.pix", i), a_px, 1);
    end

    // Mid-frame reset at (500,36).
    while (pos < 29300) begin
      tick();
      pos++;
    end
    chk("mid.h", a_h, 500);
    chk("mid.v", a_v, 36);
    chk("mid.de", a_de, 1);
    rst = 1'b1;
    tick();
    chk("mrst.h", a_h, 0);
    chk("mrst.v", a_v, 0);
    chk("mrst.pix", a_px, 0);
    chk("mrst.ls", a_ls, 0);
    chk("mrst.fs", a_fs, 0);
    chk("mrst.de", a_de, 0);
    rst = 1'b0;
    pos = -1;
    while (pos < 1) begin
      tick();
      pos++;
    end
    chk("resume.h1", a_h, 1);
    chk("resume.v1", a_v, 0);
    chk("resume.ls1", a_ls, 0);
    while (pos < 800) begin
      tick();
      pos++;
    end
    chk("resume.h800", a_h, 0);
    chk("resume.v800", a_v, 1);
    chk("resume.ls800", a_ls, 1);

    // CLK_DIV=4.
    rst4 = 1'b0;
    bad_pix = 0; bad_h = 0; npix = 0;
    first_pix = -1; nls = 0;
    ls_k[0] = -1; ls_k[1] = -1;
    for (int k = 1; k <= 6410; k++) begin
      tick();
      if (b_px !== ((k % 4) == 0)) bad_pix++;
      if (b_px === 1'b1) begin
        npix++;
        if (first_pix < 0) first_pix = k;
      end
      exp_h = 10'(((k - 1) / 4) % 800);
      if (b_h !== exp_h) bad_h++;
      if (b_ls === 1'b1) begin
        if (nls < 2) ls_k[nls] = k;
        nls++;
      end
    end
    chk("div4.first_pix", first_pix, 4);
    chk("div4.pix_pattern_bad", bad_pix, 0);
    chk("div4.pix_count", npix, 1602);
    chk("div4.h_hold_bad", bad_h, 0);
    chk("div4.ls_count", nls, 2);
    chk("div4.ls0", ls_k[0], 3201);
    chk("div4.line_len", ls_k[1] - ls_k[0], 3200);
    chk("div4.v_end", b_v, 2);

    // Reduced timing: whole frames and active-window edges.
    rsm = 1'b0;
    fs_n = 0; vs_low = 0; de_hi = 0;
    fs_k[0] = -1; fs_k[1] = -1; fs_k[2] = -1;
    fs_h = '1; fs_v = '1; fs_ls = 1'b0;
    for (int k = 1; k <= 370; k++) begin
      tick();
      for (int j = 0; j < 5; j++) begin
        if (bv[j].p == k - 1)
          chk($sformatf("sm.b%0d.de", j), s_de,
              PIPE ? bv[j].dep : bv[j].de);
      end
      if (s_fs === 1'b1) begin
        if (fs_n == 0) begin
          fs_h = s_h;
          fs_v = s_v;
          fs_ls = s_ls;
        end
        if (fs_n < 3) fs_k[fs_n] = k;
        fs_n++;
      end
      if (fs_n == 1) begin
        if (s_vs === 1'b0) vs_low++;
        if (s_de === 1'b1) de_hi++;
      end
    end
    chk("sm.fs_count", fs_n, 3);
    chk("sm.fs0", fs_k[0], 121);
    chk("sm.fs_gap1", fs_k[1] - fs_k[0], 120);
    chk("sm.fs_gap2", fs_k[2] - fs_k[1], 120);
    chk("sm.fs_h", fs_h, 0);
    chk("sm.fs_v", fs_v, 0);
    chk("sm.fs_ls", fs_ls, 1);
    chk("sm.vs_low", vs_low, 30);
    chk("sm.de_hi", de_hi, 32);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
